// File: rtl/uart_tx_chunk_streamer_pkg.sv
// Shared definitions for the chunk streamer and the future RX de-chunker:
// FSM state encoding plus header/byte-order mode constants.
package uart_tx_chunk_streamer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned GAP_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_TRIG,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam bit HDR_NONE        = 1'b0;
  localparam bit HDR_COUNT       = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/uart_chunk_byte_mux.sv
// Combinational selection of one byte from the captured chunk buffer;
// out-of-range selects yield 0.
module uart_chunk_byte_mux #(
  parameter int unsigned BUFFER_BYTE_SIZE  = 16,
  parameter int unsigned BUFFER_INDEX_SIZE = 8
) (
  input  logic [BUFFER_BYTE_SIZE*8-1:0]  buffer,
  input  logic [BUFFER_INDEX_SIZE-1:0]   sel,
  output logic [7:0]                     data
);

  always_comb begin
    data = '0;
    for (int unsigned k = 0; k < BUFFER_BYTE_SIZE; k++) begin
      if (sel == BUFFER_INDEX_SIZE'(k)) begin
        data = buffer[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/uart_tx_chunk_streamer.sv
// Captures a whole chunk on a valid/ready handshake and feeds it byte by byte
// to the UART TX, with optional length header, byte order and inter-byte gap.
module uart_tx_chunk_streamer
  import uart_tx_chunk_streamer_pkg::*;
#(
  parameter int unsigned BUFFER_BYTE_SIZE  = 16,
  parameter int unsigned BUFFER_INDEX_SIZE = 8,
  parameter bit          HEADER_ENABLE     = 1'b0,
  parameter bit          MSB_FIRST         = 1'b0,
  parameter int unsigned GAP_CYCLES        = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          chunk_valid,
  output logic                          chunk_ready,
  input  logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
  input  logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
  input  logic                          tx_done,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic                          busy,
  output logic                          chunk_sent
);

  localparam logic [BUFFER_INDEX_SIZE-1:0] MAX_N    = BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE);
  localparam logic [BUFFER_INDEX_SIZE-1:0] IDX_ONE  = BUFFER_INDEX_SIZE'(1);
  localparam logic [GAP_W-1:0]             GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t                          state_q, state_d;
  logic [BUFFER_BYTE_SIZE*8-1:0]   buffer_q, buffer_d;
  logic [BUFFER_INDEX_SIZE-1:0]    n_q, n_d;
  logic [BUFFER_INDEX_SIZE-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]                gap_q, gap_d;
  logic                            hdr_q, hdr_d;
  logic                            ready_q, ready_d;
  logic                            busy_q, busy_d;
  logic                            start_q, start_d;
  logic                            sent_q, sent_d;
  logic [7:0]                      data_q, data_d;

  logic [BUFFER_INDEX_SIZE-1:0]    n_in;
  logic [BUFFER_INDEX_SIZE-1:0]    last_idx;
  logic [BUFFER_INDEX_SIZE-1:0]    sel;
  logic [7:0]                      mux_data;

  assign n_in     = (chunk_byte_size > MAX_N) ? MAX_N : chunk_byte_size;
  assign last_idx = n_q - IDX_ONE;
  assign sel      = (MSB_FIRST == ORDER_MSB_FIRST) ? (last_idx - idx_q) : idx_q;

  uart_chunk_byte_mux #(
    .BUFFER_BYTE_SIZE (BUFFER_BYTE_SIZE),
    .BUFFER_INDEX_SIZE(BUFFER_INDEX_SIZE)
  ) u_byte_mux (
    .buffer(buffer_q),
    .sel   (sel),
    .data  (mux_data)
  );

  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    n_d      = n_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    hdr_d    = hdr_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    data_d   = data_q;
    start_d  = 1'b0;
    sent_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (chunk_valid && ready_q) begin
          buffer_d = chunk_bytes;
          n_d      = n_in;
          idx_d    = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          if (HEADER_ENABLE == HDR_COUNT) begin
            state_d = ST_HDR;
          end else if (n_in != '0) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_HDR: begin
        data_d  = 8'(n_q);
        hdr_d   = 1'b1;
        state_d = ST_TRIG;
      end
      ST_LOAD: begin
        data_d  = mux_data;
        hdr_d   = 1'b0;
        state_d = ST_TRIG;
      end
      ST_TRIG: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // First WAIT cycle coincides with the tx_start pulse; a done there is stale.
        if (tx_done && !start_q) begin
          if (hdr_q ? (n_q != '0) : (idx_q != last_idx)) begin
            if (!hdr_q) begin
              idx_d = idx_q + IDX_ONE;
            end
            if (GAP_CYCLES != 0) begin
              gap_d   = '0;
              state_d = ST_GAP;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_LOAD;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: begin
        sent_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      buffer_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      hdr_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      sent_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      hdr_q    <= hdr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      sent_q   <= sent_d;
      data_q   <= data_d;
    end
  end

  assign chunk_ready = ready_q;
  assign busy        = busy_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign chunk_sent  = sent_q;

endmodule

// File: tb/tb_uart_tx_chunk_streamer.sv
// Directed bench: instance 0 uses defaults, instance 1 has header, MSB-first
// order and a 5-cycle gap; a table of chunks plus hand sequences for corners.
module tb_uart_tx_chunk_streamer;

  logic               clk;
  logic               rst;
  logic [1:0]         cv, cr, td_in, ts, bsy, sent;
  logic [1:0][7:0]    sz, txd;
  logic [1:0][127:0]  cb;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_chunk_streamer u0 (
    .CLK(clk), .RST(rst), .chunk_valid(cv[0]), .chunk_ready(cr[0]),
    .chunk_byte_size(sz[0]), .chunk_bytes(cb[0]), .tx_done(td_in[0]),
    .tx_start(ts[0]), .tx_data(txd[0]), .busy(bsy[0]), .chunk_sent(sent[0])
  );

  uart_tx_chunk_streamer #(
    .HEADER_ENABLE(1'b1),
    .MSB_FIRST    (1'b1),
    .GAP_CYCLES   (5)
  ) u1 (
    .CLK(clk), .RST(rst), .chunk_valid(cv[1]), .chunk_ready(cr[1]),
    .chunk_byte_size(sz[1]), .chunk_bytes(cb[1]), .tx_done(td_in[1]),
    .tx_start(ts[1]), .tx_data(txd[1]), .busy(bsy[1]), .chunk_sent(sent[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [135:0] act, input logic [135:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers (or, with pre, just completes) a chunk and plays the UART side:
  // tx_done is returned resp edges after each tx_start, spurious done on edges 1..spur.
  task automatic run_chunk(input string tag, input int d, input logic [7:0] size,
      input logic [127:0] data, input int resp, input int spur, input bit hold,
      input logic [127:0] alt, input bit pre, output int n, output logic [135:0] got,
      output int first_ts, output int d2t, output int sent_lat);
    int cd;
    int last_done;
    int sent_at;
    n = 0; got = '0; first_ts = -1; d2t = -1; sent_lat = -1;
    cd = 0; last_done = -1000; sent_at = -1;
    if (!pre) begin
      check_int({tag, "_ready_before"}, int'(cr[d]), 1);
      cv[d] = 1'b1; sz[d] = size; cb[d] = data;
    end
    tick();
    if (!hold) begin
      cv[d] = 1'b0;
      sz[d] = 8'hFF;
    end
    cb[d] = alt;
    check_int({tag, "_busy_after_accept"}, int'(bsy[d]), 1);
    check_int({tag, "_ready_after_accept"}, int'(cr[d]), 0);
    for (int t = 1; t <= 600 && sent_at < 0; t++) begin
      td_in[d] = (cd == 1) || (t <= spur);
      if (cd == 1) last_done = t;
      if (cd > 0) cd--;
      tick();
      if (ts[d]) begin
        if (first_ts < 0) first_ts = t;
        else if (d2t < 0) d2t = t - last_done;
        if (n < 17) got[8*n +: 8] = txd[d];
        n++;
        cd = resp;
      end
      if (sent[d]) sent_at = t;
    end
    td_in[d] = 1'b0;
    if (sent_at < 0) check_int({tag, "_sent_timeout"}, 0, 1);
    else sent_lat = (n == 0) ? sent_at : sent_at - last_done;
  endtask

  task automatic do_chunk(input string tag, input int d, input logic [7:0] size,
      input logic [127:0] data, input int resp, input int spur, input bit hold,
      input logic [127:0] alt, input bit pre, input int exp_n,
      input logic [135:0] exp, input int exp_d2t);
    int n, first_ts, d2t, sent_lat;
    logic [135:0] got;
    run_chunk(tag, d, size, data, resp, spur, hold, alt, pre, n, got, first_ts, d2t, sent_lat);
    check_int({tag, "_count"}, n, exp_n);
    check_wide({tag, "_bytes"}, got, exp);
    if (exp_n > 0) check_int({tag, "_first_start"}, first_ts, 2);
    if (exp_n > 1) check_int({tag, "_done_to_start"}, d2t, exp_d2t);
    check_int({tag, "_sent_latency"}, sent_lat, 1);
    check_int({tag, "_busy_end"}, int'(bsy[d]), 0);
    check_int({tag, "_ready_end"}, int'(cr[d]), 1);
  endtask

  typedef struct {
    int            d;
    logic [7:0]    size;
    logic [127:0]  data;
    int            resp;
    int            spur;
    int            exp_n;
    logic [135:0]  exp;
    int            exp_d2t;
  } vec_t;

  vec_t          vecs[9];
  logic [127:0]  ramp30, rampa0;
  logic [135:0]  rev30;
  int            seen, cd, sent_cnt;

  initial begin
    for (int k = 0; k < 16; k++) begin
      ramp30[8*k +: 8] = 8'(8'h30 + k);
      rampa0[8*k +: 8] = 8'(8'hA0 + k);
    end
    rev30 = '0;
    rev30[7:0] = 8'h10;
    for (int i = 1; i <= 16; i++) rev30[8*i +: 8] = 8'(8'h30 + 16 - i);

    //          d  size    data            resp spur n   expected bytes (byte0 = lsb)   d2t
    vecs[0] = '{0, 8'd3,  128'hC3B2A1,     2,   0,   3,  136'hC3B2A1,                    2};
    vecs[1] = '{1, 8'd2,  128'h2211,       2,   0,   3,  136'h112202,                    7};
    vecs[2] = '{0, 8'd0,  128'hFFFF,       2,   0,   0,  136'h0,                         0};
    vecs[3] = '{0, 8'd40, ramp30,          3,   0,   16, {8'h00, ramp30},                2};
    vecs[4] = '{1, 8'd0,  128'h1234,       2,   0,   1,  136'h0,                         0};
    vecs[5] = '{1, 8'd40, ramp30,          2,   0,   17, rev30,                          7};
    vecs[6] = '{0, 8'd2,  128'hBEEF,       4,   3,   2,  136'hBEEF,                      2};
    vecs[7] = '{1, 8'd4,  128'h44332211,   3,   0,   5,  136'h1122334404,                7};
    vecs[8] = '{0, 8'd16, rampa0,          2,   0,   16, {8'h00, rampa0},                2};

    rst = 1'b1; cv = '0; td_in = '0; sz = '0; cb = '0;
    repeat (3) tick();
    check_int("rst_ready", int'(cr[0]), 0);
    check_int("rst_tx_start", int'(ts[0]), 0);
    check_int("rst_tx_data", int'(txd[0]), 0);
    check_int("rst_busy", int'(bsy[0]), 0);
    check_int("rst_chunk_sent", int'(sent[0]), 0);
    rst = 1'b0;
    tick();
    check_int("ready_after_release_u0", int'(cr[0]), 1);
    check_int("ready_after_release_u1", int'(cr[1]), 1);

    for (int i = 0; i < 9; i++) begin
      do_chunk($sformatf("v%0d", i), vecs[i].d, vecs[i].size, vecs[i].data,
               vecs[i].resp, vecs[i].spur, 1'b0, ~vecs[i].data, 1'b0,
               vecs[i].exp_n, vecs[i].exp, vecs[i].exp_d2t);
    end

    // chunk_valid held high: second chunk only from IDLE, carrying the data changed mid-send
    do_chunk("hold_first", 0, 8'd1, 128'h5A, 2, 0, 1'b1, 128'h77, 1'b0, 1, 136'h5A, 0);
    do_chunk("hold_second", 0, 8'd1, 128'h0, 2, 0, 1'b0, 128'h0, 1'b1, 1, 136'h77, 0);

    // reset while the 2nd of 4 bytes is in flight
    cv[0] = 1'b1; sz[0] = 8'd4; cb[0] = 128'h44332211;
    tick();
    cv[0] = 1'b0;
    seen = 0; cd = 0;
    for (int t = 0; t < 60 && seen < 2; t++) begin
      td_in[0] = (cd == 1);
      if (cd > 0) cd--;
      tick();
      if (ts[0]) begin
        seen++;
        cd = 2;
      end
    end
    td_in[0] = 1'b0;
    check_int("rstmid_reached_byte2", seen, 2);
    check_int("rstmid_byte2_data", int'(txd[0]), 8'h22);
    rst = 1'b1;
    tick();
    check_int("rstmid_tx_start", int'(ts[0]), 0);
    check_int("rstmid_tx_data", int'(txd[0]), 0);
    check_int("rstmid_busy", int'(bsy[0]), 0);
    check_int("rstmid_ready", int'(cr[0]), 0);
    check_int("rstmid_chunk_sent", int'(sent[0]), 0);
    rst = 1'b0;
    sent_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      td_in[0] = (i == 1);
      tick();
      if (sent[0]) sent_cnt++;
    end
    td_in[0] = 1'b0;
    check_int("rstmid_no_chunk_sent", sent_cnt, 0);
    check_int("rstmid_ready_after", int'(cr[0]), 1);
    do_chunk("after_rst", 0, 8'd4, 128'hDDCCBBAA, 2, 0, 1'b0, 128'h0, 1'b0,
             4, 136'hDDCCBBAA, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
